nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Sequencer that adds two NIBBLES×4-bit operands with the team's existing combinational 4-bit full adder, one nibble per clock. It sits on both sides of that adder. It feeds the adder least-significant nibble first, registers the carry between nibbles, and collects the 4-bit sum nibbles into a wide result. Operands are accepted and results are returned over valid/ready handshakes.

## Interface
- NIBBLES, 4, operand width in nibbles; operand width is 4×NIBBLES; legal range 1..16.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- in_a  input  4×NIBBLES  operand A.
- in_b  input  4×NIBBLES  operand B.
- in_cin  input  1  carry-in for the least-significant nibble.
- add_a  output  4  nibble of A driven to the adder's A input.
- add_b  output  4  nibble of B driven to the adder's B input.
- add_cin  output  1  carry driven to the adder's Cin input.
- add_sum  input  4  adder Sum (combinational from add_a/add_b/add_cin).
- add_cout  input  1  adder Cout.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  4×NIBBLES  result sum.
- out_cout  output  1  carry out of the most-significant nibble.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: load A/B shift registers, set carry_q=in_cin, set nib_cnt=0, go to RUN.
- **RUN**
  - add_a/add_b drive the low nibble of the A/B shift registers; add_cin=carry_q.
  - Each edge:
    - shift add_sum into the top nibble of the sum shift register (shift right by 4);
    - carry_q<=add_cout;
    - shift A/B right by 4;
    - nib_cnt++.
  - On the edge where nib_cnt==NIBBLES-1: go to DONE.
- **DONE**
  - out_valid=1; out_sum and out_cout (=carry_q) are held stable.
  - On out_ready: go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there; the upstream holds its request.
- add_a, add_b and add_cin are 0 in IDLE and DONE.
- Arithmetic is modulo 2^(4×NIBBLES) on out_sum; out_cout is the true carry. {out_cout,out_sum} = in_a + in_b + in_cin.
- nib_cnt is ceil(log2(NIBBLES+1)) bits wide; it never wraps within an operation.
- Reset value of every output:
  - in_ready=1;
  - out_valid=0;
  - out_sum=0;
  - out_cout=0;
  - add_a=0, add_b=0, add_cin=0.
- Reset (rst_n low) at any point, including mid-RUN or in DONE with no out_ready seen: immediately returns to IDLE and clears all registers. The in-flight operation is discarded and never reported.

## Timing
- Acceptance edge T0: RUN occupies edges T1..T(NIBBLES). out_valid rises after edge T(NIBBLES), i.e. latency is NIBBLES cycles from acceptance.
- Earliest result handshake is edge T(NIBBLES+1). Earliest next acceptance is T(NIBBLES+2). Throughput is one operation per NIBBLES+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- The only combinational dependency on the adder is add_sum/add_cout → internal registers within one cycle.

## Configuration
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- Defined:
  - adds output out_ovf (1 bit), the two's-complement signed overflow.
  - out_ovf is computed on the last RUN edge as (a_msb==b_msb)&&(sum_msb!=a_msb), using the most-significant nibble's operand bits and add_sum[3].
  - It is held in DONE, reset value 0, and cleared on IDLE entry.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package nibble_serial_adder_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the constant NIBBLE_W=4.
- One sub-module, nsa_ctrl, holds the FSM and nib_cnt. It outputs the load, shift and done strobes.
- The datapath shift registers and carry_q stay in the top level.
- The 4-bit adder is not instantiated inside. The bench and top level connect the existing full_adder_4bit to the add_* ports.

## Test plan
All scenarios use NIBBLES=4 with full_adder_4bit connected to the add_* ports.
- Reset: with rst_n held low, all outputs are at their reset values (in_ready=1, out_valid=0, out_sum=0, out_cout=0, add_*=0).
- Basic add: A=16'h00FF, B=16'h0001, cin=0 → add_a sequence F,F,0,0 and add_cin sequence 0,1,1,0; out_sum=16'h0100, out_cout=0; out_valid 4 cycles after acceptance.
- Full carry chain: A=16'hFFFF, B=16'hFFFF, cin=1 → out_sum=16'hFFFF, out_cout=1.
- Backpressure: out_ready low for 3 cycles in DONE with in_valid held high → out_valid, out_sum and out_cout stable; in_ready=0; no second acceptance until the handshake completes.
- Reset mid-operation: rst_n pulsed low during the 2nd RUN cycle → out_valid never rises, in_ready=1 immediately. A following 16'h1234+16'h4321 yields 16'h5555.
- Overflow (macro defined): A=16'h7FFF, B=16'h0001 → out_sum=16'h8000, out_ovf=1. 16'h0001+16'h0001 → out_ovf=0.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/full_adder_4bit.sv
// Existing combinational 4-bit full adder that the sequencer drives nibble by nibble.
module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

// File: rtl/nsa_ctrl.sv
// Control FSM for the nibble-serial adder: sequences IDLE -> RUN (NIBBLES cycles) -> DONE.
module nsa_ctrl
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  logic   out_ready,
  output logic   load,
  output logic   shift,
  output logic   done,
  output state_t state
);
  localparam int CNT_W = $clog2(NIBBLES + 1);

  state_t             state_q;
  logic [CNT_W-1:0]   nib_cnt;

  // load: operand acceptance edge; shift: every RUN edge; done: the final RUN edge.
  assign load  = (state_q == ST_IDLE) && in_valid;
  assign shift = (state_q == ST_RUN);
  assign done  = shift && (nib_cnt == CNT_W'(NIBBLES - 1));
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      nib_cnt <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_q <= ST_RUN;
            nib_cnt <= '0;
          end
        end
        ST_RUN: begin
          nib_cnt <= nib_cnt + CNT_W'(1);
          if (done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder datapath around an external 4-bit full adder.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4*NIBBLES-1:0]      in_a,
  input  logic [4*NIBBLES-1:0]      in_b,
  input  logic                      in_cin,
  output logic [3:0]                add_a,
  output logic [3:0]                add_b,
  output logic                      add_cin,
  input  logic [3:0]                add_sum,
  input  logic                      add_cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*NIBBLES-1:0]      out_sum,
  output logic                      out_cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic                      out_ovf
`endif
);
  localparam int W = NIBBLE_W * NIBBLES;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready and out_valid come straight from state, never from in_valid/out_ready.

  logic         load, shift, done;
  state_t       state;
  logic [W-1:0] a_q, b_q, sum_q;
  logic         carry_q;

  nsa_ctrl #(.NIBBLES(NIBBLES)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .load     (load),
    .shift    (shift),
    .done     (done),
    .state    (state)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign add_a     = shift ? a_q[NIBBLE_W-1:0] : '0;
  assign add_b     = shift ? b_q[NIBBLE_W-1:0] : '0;
  assign add_cin   = shift & carry_q;
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (load) begin
      a_q     <= in_a;
      b_q     <= in_b;
      sum_q   <= '0;
      carry_q <= in_cin;
    end else if (shift) begin
      // Sum nibbles enter at the top so the LSB nibble lands at the bottom after NIBBLES shifts.
      sum_q   <= (sum_q >> NIBBLE_W) | (W'(add_sum) << (W - NIBBLE_W));
      a_q     <= a_q >> NIBBLE_W;
      b_q     <= b_q >> NIBBLE_W;
      carry_q <= add_cout;
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q;
  assign out_ovf = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (out_valid && out_ready) begin
      ovf_q <= 1'b0;
    end else if (done) begin
      // On the last edge the low nibble of a_q/b_q is the operands' top nibble.
      ovf_q <= (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) && (add_sum[3] != a_q[NIBBLE_W-1]);
    end
  end
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) with full_adder_4bit attached.
module tb_nibble_serial_adder;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_cin;
  logic [W-1:0] in_a, in_b;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready, out_cout;
  logic [W-1:0] out_sum;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         out_ovf;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [W:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUT + adder ----------------
  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  full_adder_4bit u_fa (
    .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_cout)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int stall, input bit hold_valid);
    logic [W:0] exp;
    logic [3:0] seq_a[NIBBLES];
    logic [3:0] seq_b[NIBBLES];
    logic       seq_c[NIBBLES];
    int         cyc;
    longint     lo_a, lo_b, carry;

    exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));

    @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = hold_valid;
    in_a = W'($urandom); in_b = W'($urandom);

    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (cyc < NIBBLES) begin
        seq_a[cyc] = add_a; seq_b[cyc] = add_b; seq_c[cyc] = add_cin;
      end
      check_eq("in_ready_run", 32'(in_ready), 32'd0);
      cyc++;
      @(negedge clk);
    end
    check_eq("latency", 32'(cyc), 32'(NIBBLES));
    if (cyc >= 20) return;

    // Nibble i sees operand nibbles i and the carry out of the lower i nibbles.
    for (int i = 0; i < NIBBLES; i++) begin
      lo_a  = longint'(a) % (64'd1 << (4 * i));
      lo_b  = longint'(b) % (64'd1 << (4 * i));
      carry = (lo_a + lo_b + longint'(cin)) >> (4 * i);
      check_eq("add_a_seq", 32'(seq_a[i]), 32'((longint'(a) >> (4 * i)) % 16));
      check_eq("add_b_seq", 32'(seq_b[i]), 32'((longint'(b) >> (4 * i)) % 16));
      check_eq("add_cin_seq", 32'(seq_c[i]), 32'(carry));
    end

    exp = exp_q.pop_front();
    check_eq("out_sum", 32'(out_sum), 32'(exp[W-1:0]));
    check_eq("out_cout", 32'(out_cout), 32'(exp[W]));
    check_eq("add_a_done", 32'({add_a, add_b, add_cin}), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check_eq("out_ovf", 32'(out_ovf), 32'((a[W-1] == b[W-1]) && (exp[W-1] != a[W-1])));
`endif

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_sum", 32'(out_sum), 32'(exp[W-1:0]));
      check_eq("stall_cout", 32'(out_cout), 32'(exp[W]));
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_hs_valid", 32'(out_valid), 32'd0);
    check_eq("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_sum", 32'(out_sum), 32'd0);
    check_eq("rst_out_cout", 32'(out_cout), 32'd0);
    check_eq("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    run_op(16'h1357, 16'h2468, 1'b0, 3, 1'b1);

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    in_a = 16'hABCD; in_b = 16'h1111; in_cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_add", 32'({add_a, add_b, add_cin}), 32'd0);
    check_eq("midrst_out_sum", 32'(out_sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check_eq("midrst_no_valid", 32'(seen_valid), 32'd0);
    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);

    run_op(16'h7FFF, 16'h0001, 1'b0, 1, 1'b0);
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
